sipo_frame_deserializer: RTL and testbench
==========================================

// Module: sipo_frame_deserializer
// PURPOSE
//  Receive-side counterpart to the PISO shifter: collects an MSB-first serial bit
//  stream into N-bit words. Uses a frame_start marker for word alignment. Presents
//  each completed word on a single-entry valid/ready output buffer. Flags overruns
//  (word lost to backpressure) and resyncs (frame_start mid-word) with sticky bits.
// PARAMETERS
//  N  5  word width in bits; legal range N >= 2
// PORTS
//  clk           in   1   single clock, all state updates on posedge
//  rst           in   1   asynchronous, active-high reset
//  serial_in     in   1   serial data bit, MSB of word first
//  bit_valid     in   1   serial_in is a real bit this cycle
//  frame_start   in   1   qualifies the current bit as the MSB of a new word; ignored unless bit_valid=1
//  out_ready     in   1   downstream accepts parallel_out this cycle
//  clr_err       in   1   synchronous clear of overrun and frame_err
//  parallel_out  out  N   completed word, bit N-1 = first bit received
//  out_valid     out  1   parallel_out holds an unconsumed word
//  busy          out  1   a frame is partially received (state SHIFT)
//  overrun       out  1   sticky: a completed word was dropped
//  frame_err     out  1   sticky: frame_start seen before previous word completed
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, shift reg=0, bit_cnt=0. Outputs parallel_out=0,
//   out_valid=0, busy=0, overrun=0, frame_err=0. Reset mid-frame discards the partial word.
//  bit_cnt width = $clog2(N+1); shift: sreg <= {sreg[N-2:0], serial_in}.
//  bit_valid=0: no shift, no count, no state change. Output handshake still operates.
//  FSM IDLE:
//   - bit_valid & frame_start: shift bit in, bit_cnt=1, go SHIFT.
//   - bit_valid without frame_start: bit discarded, stay IDLE.
//  FSM SHIFT (busy=1):
//   - bit_valid & ~frame_start & bit_cnt<N-1: shift, bit_cnt++.
//   - bit_valid & ~frame_start & bit_cnt==N-1: word complete. Go IDLE, bit_cnt=0.
//   - bit_valid & frame_start: resync. Discard partial, set frame_err, treat bit as
//     bit 1 of a new word (sreg <= serial_in, bit_cnt=1), stay SHIFT.
//  Word complete: word = {sreg[N-2:0], serial_in}.
//   - If out_valid=0, or out_valid=1 & out_ready=1 in the same cycle: parallel_out<=word,
//     out_valid<=1.
//   - Else (out_valid=1 & out_ready=0): word dropped, overrun<=1, parallel_out unchanged.
//  Latency: Nth bit sampled at edge k -> out_valid=1 and word visible after edge k.
//  Handshake: transfer when out_valid & out_ready at a posedge.
//   - On transfer with no new word: out_valid<=0.
//   - parallel_out holds its value while out_valid=1 & ~out_ready.
//   - parallel_out keeps the last word after a transfer (not cleared).
//  N=2 edge: IDLE start bit -> SHIFT; the next valid bit completes the word.
//  Sticky flags: set has priority over clr_err when both occur in the same cycle.
//   clr_err otherwise clears both flags on the next edge.
//  Back-to-back frames: frame_start may accompany the bit right after a completing bit.
//   No idle cycle is required.
// TESTING
//  T1 basic: N=5, out_ready=1; bits 1,0,1,1,0 with bit_valid=1 and frame_start on the first
//     -> after edge of 5th bit parallel_out=5'h16, out_valid=1 one cycle, busy 1->0.
//  T2 gaps: same frame with bit_valid=0 idle cycles between bits -> identical 5'h16,
//     no early out_valid, no flags.
//  T3 backpressure: out_ready=0; frame 5'h16 then frame 0,1,0,0,1 -> parallel_out stays 5'h16,
//     overrun=1; raise out_ready for one cycle -> out_valid=0.
//  T4 simultaneous: out_valid=1 and out_ready=1 on the same edge a new word 5'h09 completes
//     -> parallel_out=5'h09, out_valid stays 1, overrun=0.
//  T5 resync: frame_start after 3 bits, then bits 1,1,1,1,1 -> frame_err=1,
//     parallel_out=5'h1F; then clr_err -> frame_err=0.
//  T6 reset: assert rst after 2 bits of a frame -> all outputs 0 immediately, state IDLE.
//     Bits without frame_start are ignored; the next framed 5'h0A is received correctly.

Source files
------------

// File: rtl/sipo_frame_deserializer_if.sv
// Bundle of serial input, output handshake and status signals of the SIPO frame deserializer.
// The master modport is the stimulus/consumer side; the slave modport is the deserializer.
interface sipo_frame_deserializer_if #(
  parameter int N = 5
);
  logic         serial_in;
  logic         bit_valid;
  logic         frame_start;
  logic         out_ready;
  logic         clr_err;
  logic [N-1:0] parallel_out;
  logic         out_valid;
  logic         busy;
  logic         overrun;
  logic         frame_err;

  modport master (
    output serial_in, bit_valid, frame_start, out_ready, clr_err,
    input  parallel_out, out_valid, busy, overrun, frame_err
  );

  modport slave (
    input  serial_in, bit_valid, frame_start, out_ready, clr_err,
    output parallel_out, out_valid, busy, overrun, frame_err
  );
endinterface

// File: rtl/sipo_frame_deserializer.sv
// MSB-first serial-to-parallel deserializer with frame_start alignment, a single-entry
// valid/ready output buffer and sticky overrun / frame error flags.
module sipo_frame_deserializer #(
  parameter int N = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  sipo_frame_deserializer_if.slave    bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [N-1:0]   r_sreg;
  logic [N-1:0]   w_sreg_next;
  logic [CW-1:0]  r_bit_cnt;
  logic [CW-1:0]  w_bit_cnt_next;
  logic           w_word_done;
  logic           w_resync;
  logic [N-1:0]   w_word;

  logic [N-1:0]   r_parallel_out;
  logic           r_out_valid;
  logic           r_overrun;
  logic           r_frame_err;
  logic           w_drop;

  assign w_word = {r_sreg[N-2:0], bus.serial_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sreg    <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_sreg    <= w_sreg_next;
      r_bit_cnt <= w_bit_cnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_sreg_next    = r_sreg;
    w_bit_cnt_next = r_bit_cnt;
    w_word_done    = 1'b0;
    w_resync       = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Bits arriving outside a frame are discarded until a frame_start aligns us.
        if (bus.bit_valid && bus.frame_start) begin
          w_sreg_next    = w_word;
          w_bit_cnt_next = CW'(1);
          w_state_next   = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.bit_valid) begin
          if (bus.frame_start) begin
            w_resync       = 1'b1;
            w_sreg_next    = {{(N-1){1'b0}}, bus.serial_in};
            w_bit_cnt_next = CW'(1);
          end else if (r_bit_cnt == CW'(N - 1)) begin
            w_word_done    = 1'b1;
            w_sreg_next    = w_word;
            w_bit_cnt_next = '0;
            w_state_next   = IDLE;
          end else begin
            w_sreg_next    = w_word;
            w_bit_cnt_next = r_bit_cnt + CW'(1);
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // A completed word is lost only when the buffer is full and not being drained this edge.
  assign w_drop = w_word_done && r_out_valid && !bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parallel_out <= '0;
      r_out_valid    <= 1'b0;
    end else if (w_word_done && !w_drop) begin
      r_parallel_out <= w_word;
      r_out_valid    <= 1'b1;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid    <= 1'b0;
    end
  end

  // Setting a flag wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= (r_overrun   && !bus.clr_err) || w_drop;
      r_frame_err <= (r_frame_err && !bus.clr_err) || w_resync;
    end
  end

  assign bus.parallel_out = r_parallel_out;
  assign bus.out_valid    = r_out_valid;
  assign bus.busy         = (r_state == SHIFT);
  assign bus.overrun      = r_overrun;
  assign bus.frame_err    = r_frame_err;
endmodule

// File: tb/tb_sipo_frame_deserializer.sv
// Directed bench for sipo_frame_deserializer (N=5): framing, gaps, backpressure,
// simultaneous drain/refill, resync, clear priority and mid-frame reset.
module tb_sipo_frame_deserializer;
  localparam int N = 5;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  sipo_frame_deserializer_if #(.N(N)) bus ();

  sipo_frame_deserializer #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Present one valid bit for one edge; return 1 time unit after that edge.
  task automatic drive_bit(input logic b, input logic fs);
    bus.serial_in   = b;
    bus.bit_valid   = 1'b1;
    bus.frame_start = fs;
    @(posedge clk);
    #1;
    bus.bit_valid   = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [4:0] w);
    for (int i = N - 1; i >= 0; i--) drive_bit(w[i], i == N - 1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst             = 1'b1;
    bus.serial_in   = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.out_ready   = 1'b0;
    bus.clr_err     = 1'b0;
    idle(2);
    check("rst_pout",  8'(bus.parallel_out), 8'h00);
    check("rst_valid", 8'(bus.out_valid),    8'h0);
    check("rst_busy",  8'(bus.busy),         8'h0);
    check("rst_ovr",   8'(bus.overrun),      8'h0);
    check("rst_ferr",  8'(bus.frame_err),    8'h0);
    rst = 1'b0;
    idle(1);

    // T1: basic frame 1,0,1,1,0 with ready held high
    bus.out_ready = 1'b1;
    drive_bit(1'b1, 1'b1);
    check("t1_busy_start", 8'(bus.busy), 8'h1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    check("t1_no_early_valid", 8'(bus.out_valid), 8'h0);
    drive_bit(1'b0, 1'b0);
    check("t1_pout",  8'(bus.parallel_out), 8'h16);
    check("t1_valid", 8'(bus.out_valid),    8'h1);
    check("t1_busy",  8'(bus.busy),         8'h0);
    idle(1);
    check("t1_drained", 8'(bus.out_valid),    8'h0);
    check("t1_kept",    8'(bus.parallel_out), 8'h16);

    // T2: same frame with idle gaps between bits
    drive_bit(1'b1, 1'b1); idle(2);
    drive_bit(1'b0, 1'b0); idle(1);
    drive_bit(1'b1, 1'b0); idle(1);
    drive_bit(1'b1, 1'b0); idle(3);
    check("t2_no_early_valid", 8'(bus.out_valid), 8'h0);
    check("t2_busy_gap",       8'(bus.busy),      8'h1);
    drive_bit(1'b0, 1'b0);
    check("t2_pout",  8'(bus.parallel_out), 8'h16);
    check("t2_valid", 8'(bus.out_valid),    8'h1);
    check("t2_ovr",   8'(bus.overrun),      8'h0);
    check("t2_ferr",  8'(bus.frame_err),    8'h0);
    idle(1);

    // T3: backpressure drops the second word
    bus.out_ready = 1'b0;
    send_word(5'h16);
    check("t3_first", 8'(bus.parallel_out), 8'h16);
    send_word(5'h09);
    check("t3_pout_held", 8'(bus.parallel_out), 8'h16);
    check("t3_ovr",       8'(bus.overrun),      8'h1);
    check("t3_valid",     8'(bus.out_valid),    8'h1);
    bus.out_ready = 1'b1;
    idle(1);
    bus.out_ready = 1'b0;
    check("t3_drained",  8'(bus.out_valid), 8'h0);
    check("t3_ovr_stky", 8'(bus.overrun),   8'h1);
    bus.clr_err = 1'b1;
    idle(1);
    bus.clr_err = 1'b0;
    check("t3_ovr_clr", 8'(bus.overrun), 8'h0);

    // T4: drain and refill on the same edge
    send_word(5'h16);
    check("t4_full", 8'(bus.out_valid), 8'h1);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    bus.out_ready = 1'b1;
    drive_bit(1'b1, 1'b0);
    check("t4_pout",  8'(bus.parallel_out), 8'h09);
    check("t4_valid", 8'(bus.out_valid),    8'h1);
    check("t4_ovr",   8'(bus.overrun),      8'h0);
    idle(1);

    // T5: resync after 3 bits, then 1,1,1,1,1
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b1);
    check("t5_ferr", 8'(bus.frame_err), 8'h1);
    check("t5_busy", 8'(bus.busy),      8'h1);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    check("t5_pout", 8'(bus.parallel_out), 8'h1F);
    bus.clr_err = 1'b1;
    idle(1);
    bus.clr_err = 1'b0;
    check("t5_ferr_clr", 8'(bus.frame_err), 8'h0);

    // Set beats clear when a resync coincides with clr_err
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b0);
    bus.clr_err = 1'b1;
    drive_bit(1'b1, 1'b1);
    bus.clr_err = 1'b0;
    check("prio_ferr", 8'(bus.frame_err), 8'h1);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0);
    check("prio_pout", 8'(bus.parallel_out), 8'h10);
    idle(1);

    // T6: asynchronous reset mid-frame
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b0);
    check("t6_busy_pre", 8'(bus.busy), 8'h1);
    #2 rst = 1'b1;
    #1;
    check("t6_pout",  8'(bus.parallel_out), 8'h00);
    check("t6_valid", 8'(bus.out_valid),    8'h0);
    check("t6_busy",  8'(bus.busy),         8'h0);
    check("t6_ferr",  8'(bus.frame_err),    8'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    check("t6_ignored", 8'(bus.busy), 8'h0);
    check("t6_no_word", 8'(bus.out_valid), 8'h0);
    send_word(5'h0A);
    check("t6_pout_after", 8'(bus.parallel_out), 8'h0A);
    check("t6_valid_after", 8'(bus.out_valid),   8'h1);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
